// File: rtl/ddr_write_master_pkg.sv
// Shared types and default sizes for the DDR write master.
// Holds the FSM state enum and the default parameter constants.
package ddr_write_master_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/ddr_write_master_if.sv
// Avalon-MM write-only bus between the write master and a memory slave.
// Ports: address, write, byteenable, writedata (master out), waitrequest (slave out).
interface ddr_write_master_if
    import ddr_write_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0]   master_address;
    logic                    master_write;
    logic [DATA_WIDTH/8-1:0] master_byteenable;
    logic [DATA_WIDTH-1:0]   master_writedata;
    logic                    master_waitrequest;

    modport master (
        output master_address,
        output master_write,
        output master_byteenable,
        output master_writedata,
        input  master_waitrequest
    );

    modport slave (
        input  master_address,
        input  master_write,
        input  master_byteenable,
        input  master_writedata,
        output master_waitrequest
    );

endinterface

// File: rtl/ddr_wm_fifo.sv
// Show-ahead synchronous FIFO: head is the oldest word, valid while !empty.
// Ports: clk, reset_n, push/push_data, pop, head, full, empty, count.
module ddr_wm_fifo
    import ddr_write_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  push_ok;
    logic                  pop_ok;

    // A push into a full buffer is dropped even when a pop frees a
    // slot on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];
    assign count = cnt;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ddr_write_master.sv
// Streams buffered user words to Avalon-MM as one write per word.
// Ports: clk, reset_n, control_* (go/base/length/fixed/done),
//        user_* (push/data/full), avm (Avalon-MM master bus).
module ddr_write_master
    import ddr_write_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  control_fixed_location,
    input  logic [ADDR_WIDTH-1:0] control_write_base,
    input  logic [ADDR_WIDTH-1:0] control_write_length,
    input  logic                  control_go,
    output logic                  control_done,
    input  logic                  user_write_buffer,
    input  logic [DATA_WIDTH-1:0] user_buffer_data,
    output logic                  user_buffer_full,
    ddr_write_master_if.master    avm
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BPW_A    = ADDR_WIDTH'(BPW);
    localparam logic [ADDR_WIDTH-1:0] LEN_MASK = ~ADDR_WIDTH'(BPW - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic [ADDR_WIDTH-1:0]   rem_nx;
    logic [ADDR_WIDTH-1:0]   len_aligned;
    logic                    fixed_q;
    logic                    fixed_nx;
    logic                    done_q;
    logic                    done_nx;
    logic                    accept;

    logic [DATA_WIDTH-1:0]         head;
    logic                          empty;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   unused_count;

    ddr_wm_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (user_write_buffer),
        .push_data (user_buffer_data),
        .pop       (accept),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (unused_count)
    );

    // Sub-word length bits carry no meaning; a length below one word
    // becomes zero and the go only blips done.
    assign len_aligned = control_write_length & LEN_MASK;

    assign avm.master_write      = (state == WRITE) && !empty;
    assign avm.master_address    = addr;
    assign avm.master_writedata  = head;
    assign avm.master_byteenable = '1;
    assign accept = avm.master_write && !avm.master_waitrequest;

    assign control_done     = done_q;
    assign user_buffer_full = full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            fixed_q   <= 1'b0;
            done_q    <= 1'b1;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            remaining <= rem_nx;
            fixed_q   <= fixed_nx;
            done_q    <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        rem_nx   = remaining;
        fixed_nx = fixed_q;
        done_nx  = done_q;
        unique case (state)
            IDLE: begin
                done_nx = 1'b1;
                if (control_go) begin
                    done_nx  = 1'b0;
                    addr_nx  = control_write_base;
                    rem_nx   = len_aligned;
                    fixed_nx = control_fixed_location;
                    if (len_aligned != '0) begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    rem_nx = remaining - BPW_A;
                    if (!fixed_q) begin
                        addr_nx = addr + BPW_A;
                    end
                    // Last word: finish on the accepting edge.
                    if (remaining == BPW_A) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ddr_write_master.sv
// Directed bench for ddr_write_master: vector table of transfers plus
// hand sequences for full buffer, overlap, busy/zero go and reset.
module tb_ddr_write_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        control_fixed_location = 1'b0;
    logic [31:0] control_write_base = '0;
    logic [31:0] control_write_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        user_write_buffer = 1'b0;
    logic [31:0] user_buffer_data = '0;
    logic        user_buffer_full;

    ddr_write_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) avm ();

    ddr_write_master #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (16)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .avm                    (avm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             fixed;
        logic [31:0]      base;
        logic [31:0]      len;
        logic [3:0]       n_push;
        logic [3:0][31:0] data;
        logic [3:0]       wait_idx;
        logic [3:0]       wait_n;
        logic [3:0]       n_exp;
        logic [3:0][31:0] exp_addr;
        logic [3:0][31:0] exp_data;
        logic [4:0]       cycles;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: logs every accepted word, checks stall stability.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall) begin
                chk("hold_write", {31'd0, avm.master_write}, 32'd1);
                chk("hold_addr", avm.master_address, prev_addr);
                chk("hold_data", avm.master_writedata, prev_data);
            end
            prev_stall = avm.master_write && avm.master_waitrequest;
            prev_addr  = avm.master_address;
            prev_data  = avm.master_writedata;
            if (prev_stall) stall_cnt++;
            if (avm.master_write && !avm.master_waitrequest) begin
                q_addr.push_back(avm.master_address);
                q_data.push_back(avm.master_writedata);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] d);
        user_write_buffer = 1'b1;
        user_buffer_data  = d;
        cyc(1);
        user_write_buffer = 1'b0;
    endtask

    task automatic go(input logic fx, input logic [31:0] b,
                      input logic [31:0] l);
        control_fixed_location = fx;
        control_write_base     = b;
        control_write_length   = l;
        control_go             = 1'b1;
        cyc(1);
        control_go = 1'b0;
    endtask

    // Steps until done, stalling word widx for wn cycles.
    task automatic run(input int widx, input int wn, input int budget,
                       output int cycles);
        int  left;
        logic seen;
        left   = wn;
        cycles = 0;
        seen   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (q_data.size() == widx && avm.master_write && left > 0) begin
                avm.master_waitrequest = 1'b1;
                left--;
            end else begin
                avm.master_waitrequest = 1'b0;
            end
            cyc(1);
            cycles++;
            if (control_done) begin
                seen = 1'b1;
                break;
            end
        end
        avm.master_waitrequest = 1'b0;
        if (!seen) chk("done_timeout", {31'd0, control_done}, 32'd1);
    endtask

    function automatic vec_t mk(input logic fx, input logic [31:0] b,
                                input logic [31:0] l, input int np,
                                input int wi, input int wn,
                                input int ne, input int cy);
        vec_t v;
        v          = '0;
        v.fixed    = fx;
        v.base     = b;
        v.len      = l;
        v.n_push   = 4'(np);
        v.wait_idx = 4'(wi);
        v.wait_n   = 4'(wn);
        v.n_exp    = 4'(ne);
        v.cycles   = 5'(cy);
        return v;
    endfunction

    vec_t vecs [6];

    initial begin
        int cy;
        int q0;
        avm.master_waitrequest = 1'b0;

        // Vector lists below are written highest index first.
        vecs[0] = mk(0, 32'h1000_0000, 32'd4, 1, 0, 0, 1, 1);
        vecs[0].data     = {32'h0, 32'h0, 32'h0, 32'd13};
        vecs[0].exp_addr = {32'h0, 32'h0, 32'h0, 32'h1000_0000};
        vecs[0].exp_data = {32'h0, 32'h0, 32'h0, 32'd13};

        vecs[1] = mk(0, 32'h1000_0000, 32'd16, 4, 1, 3, 4, 7);
        vecs[1].data     = {32'h44, 32'h33, 32'h22, 32'h11};
        vecs[1].exp_addr = {32'h1000_000C, 32'h1000_0008,
                            32'h1000_0004, 32'h1000_0000};
        vecs[1].exp_data = {32'h44, 32'h33, 32'h22, 32'h11};

        vecs[2] = mk(1, 32'h0000_2000, 32'd8, 2, 0, 0, 2, 2);
        vecs[2].data     = {32'h0, 32'h0, 32'd2, 32'd1};
        vecs[2].exp_addr = {32'h0, 32'h0, 32'h2000, 32'h2000};
        vecs[2].exp_data = {32'h0, 32'h0, 32'd2, 32'd1};

        vecs[3] = mk(0, 32'hFFFF_FFF8, 32'd12, 3, 0, 0, 3, 3);
        vecs[3].data     = {32'h0, 32'hC, 32'hB, 32'hA};
        vecs[3].exp_addr = {32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
        vecs[3].exp_data = {32'h0, 32'hC, 32'hB, 32'hA};

        vecs[4] = mk(0, 32'h0000_0300, 32'd7, 2, 0, 0, 1, 1);
        vecs[4].data     = {32'h0, 32'h0, 32'h66, 32'h55};
        vecs[4].exp_addr = {32'h0, 32'h0, 32'h0, 32'h300};
        vecs[4].exp_data = {32'h0, 32'h0, 32'h0, 32'h55};

        vecs[5] = mk(0, 32'h0000_0040, 32'd4, 0, 0, 0, 1, 1);
        vecs[5].exp_addr = {32'h0, 32'h0, 32'h0, 32'h40};
        vecs[5].exp_data = {32'h0, 32'h0, 32'h0, 32'h66};

        cyc(3);
        chk("rst_done", {31'd0, control_done}, 32'd1);
        chk("rst_write", {31'd0, avm.master_write}, 32'd0);
        chk("rst_full", {31'd0, user_buffer_full}, 32'd0);
        chk("rst_addr", avm.master_address, 32'd0);
        chk("rst_be", {28'd0, avm.master_byteenable}, 32'hF);
        reset_n = 1'b1;
        cyc(1);

        for (int k = 0; k < 6; k++) begin
            q_addr.delete();
            q_data.delete();
            stall_cnt = 0;
            for (int i = 0; i < int'(vecs[k].n_push); i++) begin
                push(vecs[k].data[i]);
            end
            go(vecs[k].fixed, vecs[k].base, vecs[k].len);
            chk($sformatf("v%0d_done_low", k), {31'd0, control_done}, 32'd0);
            run(int'(vecs[k].wait_idx), int'(vecs[k].wait_n), 40, cy);
            chk($sformatf("v%0d_cycles", k), cy, 32'(vecs[k].cycles));
            chk($sformatf("v%0d_wr_after", k),
                {31'd0, avm.master_write}, 32'd0);
            chk($sformatf("v%0d_stalls", k), stall_cnt,
                32'(vecs[k].wait_n));
            chk($sformatf("v%0d_nwr", k), q_data.size(),
                32'(vecs[k].n_exp));
            for (int i = 0; i < int'(vecs[k].n_exp); i++) begin
                if (i < q_data.size()) begin
                    chk($sformatf("v%0d_addr%0d", k, i), q_addr[i],
                        vecs[k].exp_addr[i]);
                    chk($sformatf("v%0d_data%0d", k, i), q_data[i],
                        vecs[k].exp_data[i]);
                end
            end
        end

        // Fill to full, overflow, then drain 16 words.
        for (int i = 0; i < 17; i++) begin
            push(32'h100 + 32'(i));
            if (i == 14) chk("full_15", {31'd0, user_buffer_full}, 32'd0);
            if (i >= 15) chk($sformatf("full_%0d", i + 1),
                             {31'd0, user_buffer_full}, 32'd1);
        end
        q_addr.delete();
        q_data.delete();
        go(1'b0, 32'h5000, 32'd64);
        push(32'hDEAD);
        run(0, 0, 60, cy);
        chk("full_cycles", cy, 32'd15);
        chk("full_nwr", q_data.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < q_data.size()) begin
                chk($sformatf("full_data%0d", i), q_data[i],
                    32'h100 + 32'(i));
                chk($sformatf("full_addr%0d", i), q_addr[i],
                    32'h5000 + 32'(4 * i));
            end
        end

        // Empty buffer while writing: wait without timing out.
        q_addr.delete();
        q_data.delete();
        go(1'b0, 32'h6000, 32'd4);
        cyc(3);
        chk("empty_write", {31'd0, avm.master_write}, 32'd0);
        chk("empty_done", {31'd0, control_done}, 32'd0);
        chk("empty_nwr", q_data.size(), 32'd0);
        push(32'h77);
        run(0, 0, 20, cy);
        chk("late_cycles", cy, 32'd1);
        chk("late_nwr", q_data.size(), 32'd1);
        if (q_data.size() > 0) begin
            chk("late_data", q_data[0], 32'h77);
            chk("late_addr", q_addr[0], 32'h6000);
        end

        // Push and pop on the same edges keeps order.
        q_addr.delete();
        q_data.delete();
        push(32'hA1);
        go(1'b0, 32'h7000, 32'd12);
        user_write_buffer = 1'b1;
        user_buffer_data  = 32'hA2;
        cyc(1);
        user_buffer_data  = 32'hA3;
        cyc(1);
        user_write_buffer = 1'b0;
        run(0, 0, 20, cy);
        chk("pp_cycles", cy, 32'd1);
        chk("pp_nwr", q_data.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_data.size()) begin
                chk($sformatf("pp_data%0d", i), q_data[i],
                    32'hA1 + 32'(i));
                chk($sformatf("pp_addr%0d", i), q_addr[i],
                    32'h7000 + 32'(4 * i));
            end
        end

        // Go while busy is ignored.
        q_addr.delete();
        q_data.delete();
        go(1'b0, 32'h8000, 32'd8);
        go(1'b1, 32'h9000, 32'd4);
        push(32'hB1);
        push(32'hB2);
        run(0, 0, 20, cy);
        chk("busy_nwr", q_data.size(), 32'd2);
        if (q_data.size() == 2) begin
            chk("busy_addr0", q_addr[0], 32'h8000);
            chk("busy_addr1", q_addr[1], 32'h8004);
            chk("busy_data1", q_data[1], 32'hB2);
        end

        // Zero and sub-word length: done dips for one cycle only.
        go(1'b0, 32'h1234, 32'd0);
        chk("zero_done_low", {31'd0, control_done}, 32'd0);
        chk("zero_write", {31'd0, avm.master_write}, 32'd0);
        cyc(1);
        chk("zero_done_back", {31'd0, control_done}, 32'd1);
        go(1'b0, 32'h1234, 32'd3);
        chk("sub_done_low", {31'd0, control_done}, 32'd0);
        cyc(1);
        chk("sub_done_back", {31'd0, control_done}, 32'd1);
        chk("zero_nwr", q_data.size(), 32'd2);

        // Reset mid-transfer abandons it.
        q_addr.delete();
        q_data.delete();
        go(1'b0, 32'hA000, 32'd8);
        push(32'hC1);
        for (int c = 0; c < 10; c++) begin
            if (q_data.size() >= 1) break;
            cyc(1);
        end
        cyc(1);
        chk("mid_nwr", q_data.size(), 32'd1);
        chk("mid_done", {31'd0, control_done}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("arst_done", {31'd0, control_done}, 32'd1);
        chk("arst_write", {31'd0, avm.master_write}, 32'd0);
        chk("arst_addr", avm.master_address, 32'd0);
        chk("arst_full", {31'd0, user_buffer_full}, 32'd0);
        cyc(1);
        reset_n = 1'b1;
        push(32'hC2);
        cyc(4);
        chk("post_nwr", q_data.size(), 32'd1);
        chk("post_write", {31'd0, avm.master_write}, 32'd0);
        chk("post_done", {31'd0, control_done}, 32'd1);

        q0 = n_fail;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, q0);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ddr_write_master.md
DDR_WRITE_MASTER -- requirements
Module: ddr_write_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of user and Avalon data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning buffer depth in words; must be a power of two, at least 2.
REQ-004 SHALL have ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous reset, active-low.
- control_fixed_location  in  1  1 = hold address constant for the whole transfer.
- control_write_base  in  ADDR_WIDTH  start byte address, sampled on go.
- control_write_length  in  ADDR_WIDTH  transfer length in bytes, sampled on go.
- control_go  in  1  start pulse.
- control_done  out  1  1 = idle, no transfer pending.
- user_write_buffer  in  1  push strobe into the buffer.
- user_buffer_data  in  DATA_WIDTH  word to push.
- user_buffer_full  out  1  buffer holds FIFO_DEPTH words.
- master_address  out  ADDR_WIDTH  Avalon-MM byte address.
- master_write  out  1  Avalon-MM write request.
- master_byteenable  out  DATA_WIDTH/8  all ones.
- master_writedata  out  DATA_WIDTH  Avalon-MM write data.
- master_waitrequest  in  1  Avalon-MM slave stall.

Function
REQ-005 SHALL use BPW = DATA_WIDTH/8; control_write_length SHALL be a multiple of BPW; low bits below BPW SHALL be ignored.
REQ-006 SHALL implement an FSM with states IDLE and WRITE.
REQ-007 IDLE: control_go=1 SHALL latch base, length, and fixed_location; go SHALL enter WRITE and clear control_done on the same edge.
REQ-008 IDLE, go with length < BPW: the FSM SHALL stay in IDLE; control_done SHALL drop for exactly one cycle and then return to 1.
REQ-009 control_go in WRITE SHALL be ignored, with no effect on the latched values.
REQ-010 master_write SHALL be high iff the state is WRITE and the buffer is not empty.
REQ-011 master_writedata SHALL be the buffer head word (show-ahead).
REQ-012 A word is accepted when master_write=1 and master_waitrequest=0.
REQ-013 While master_waitrequest=1, address, data, and write SHALL be held stable.
REQ-014 On word acceptance:
- the buffer SHALL pop.
- remaining SHALL decrease by BPW.
- master_address SHALL increase by BPW unless fixed; the address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-015 The acceptance that brings remaining to 0 SHALL return the FSM to IDLE and set control_done=1 on the same edge; master_write SHALL be 0 in the following cycle.
REQ-016 The buffer SHALL accept pushes in any state, so data may be preloaded before go.
REQ-017 user_buffer_full SHALL reflect count==FIFO_DEPTH after the current edge.
REQ-018 A push while full SHALL be dropped, even if a pop occurs the same cycle.
REQ-019 A simultaneous push and pop when not full SHALL leave the count unchanged and keep data order.
REQ-020 Words left in the buffer after done SHALL be retained for the next transfer.
REQ-021 When the buffer is empty in WRITE, the FSM SHALL stay in WRITE with master_write=0; it SHALL not time out.

Reset
REQ-022 reset_n=0 SHALL asynchronously do all of the following:
- force IDLE.
- flush the buffer: count 0, pointers 0.
- set control_done=1, master_write=0, user_buffer_full=0, master_address=0, remaining=0.
REQ-023 Reset mid-transfer SHALL abandon the transfer with no further writes.
REQ-024 Release of reset SHALL be synchronised externally; the first go SHALL be honoured no earlier than the first edge after release.

Structure
REQ-025 Package ddr_write_master_pkg SHALL hold the state enum {IDLE, WRITE} and default parameter constants.
REQ-026 Sub-module ddr_wm_fifo SHALL implement the show-ahead synchronous FIFO with full, empty, and count; ddr_write_master SHALL hold the FSM, address counter, and length counter.

Verification
REQ-027 Preload one word 13, then go with base 0x10000000, length 4, no waitrequest. Required: one write at 0x10000000 with data 13; done rises on that edge.
REQ-028 Push 0x11, 0x22, 0x33, 0x44, then go with base 0x10000000, length 16. waitrequest is high for 3 cycles on the second word. Required: writes at 0x10000000, 0x10000004, 0x10000008, 0x1000000C; the second word is held for 3 cycles.
REQ-029 fixed_location=1, length 8, data 1 and 2. Required: both writes at the base address.
REQ-030 Push 17 words with FIFO_DEPTH=16 and no go. Required: full=1 after the 16th push; the 17th word is dropped; a later length-64 transfer writes words 1 through 16 only.
REQ-031 go with length 8 and an empty buffer; push one word; assert reset_n=0 for 1 cycle; then push. Required: 1 write; after reset, done=1 and write=0 with no further writes.
REQ-032 go while busy, and go with length 0. Required: the busy go is ignored; the zero-length go pulses done low for one cycle with no write.
